// File: rtl/hawk_pgrd_mngr_if.sv
// Bundle of the request, AXI4 read-channel and consumer signals for the page read manager.
// master: the manager's view; slave: the view of the environment around it.
interface hawk_pgrd_mngr_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 512,
   parameter int unsigned ID_W   = 4
);
   // Read request
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [6:0]        req_ncl;
   // AXI4 read address channel
   logic [ID_W-1:0]   m_axi_arid;
   logic [ADDR_W-1:0] m_axi_araddr;
   logic [7:0]        m_axi_arlen;
   logic [2:0]        m_axi_arsize;
   logic [1:0]        m_axi_arburst;
   logic              m_axi_arvalid;
   logic              m_axi_arready;
   // AXI4 read data channel
   logic [DATA_W-1:0] m_axi_rdata;
   logic [1:0]        m_axi_rresp;
   logic              m_axi_rlast;
   logic              m_axi_rvalid;
   logic              m_axi_rready;
   // Cacheline stream to the consumer
   logic [DATA_W-1:0] cl_data;
   logic              cl_valid;
   logic              cl_ready;
   logic              cl_last;
   // Completion status
   logic              done;
   logic              err;

   modport master (
      input  req_valid, req_addr, req_ncl,
      output req_ready,
      output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
      input  m_axi_arready,
      input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
      output m_axi_rready,
      output cl_data, cl_valid, cl_last,
      input  cl_ready,
      output done, err
   );

   modport slave (
      output req_valid, req_addr, req_ncl,
      input  req_ready,
      input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
      output m_axi_arready,
      output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
      input  m_axi_rready,
      input  cl_data, cl_valid, cl_last,
      output cl_ready,
      input  done, err
   );
endinterface

// File: rtl/hawk_pgrd_mngr.sv
// Page read manager: splits a request for N cachelines into AXI4 INCR read bursts that never
// cross a 4 KB boundary, streams the returned lines to the consumer as a pure pass-through and
// reports completion with a sticky error flag.
module hawk_pgrd_mngr #(
   parameter int unsigned ADDR_W    = 64,
   parameter int unsigned DATA_W    = 512,
   parameter int unsigned ID_W      = 4,
   parameter int unsigned RD_ID     = 0,
   parameter int unsigned BURST_MAX = 16
) (
   input logic              clk_i,
   input logic              rst_ni,
   hawk_pgrd_mngr_if.master bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_AR   = 2'd1;
   localparam logic [1:0] ST_RD   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [6:0] BMAX = 7'(BURST_MAX);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [6:0]        rem_q, rem_d;
   logic [6:0]        bcnt_q, bcnt_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] araddr_q;
   logic [6:0]        arlen_q;
   logic [6:0]        room_d, blen_d;
   logic              in_rd, r_hs, ar_load;
   logic [DATA_W-1:0] rdata;

   assign in_rd   = (state_q == ST_RD);
   assign r_hs    = in_rd && bus.m_axi_rvalid && bus.cl_ready;
   // AR address/length are captured on every entry into AR so they stay stable under arvalid.
   assign ar_load = (state_d == ST_AR) && (state_q != ST_AR);

   // Next-state, address/remaining/beat bookkeeping and error accumulation.
   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      rem_d      = rem_q;
      bcnt_d     = bcnt_q;
      err_d      = err_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               cur_addr_d = {bus.req_addr[ADDR_W-1:6], 6'b0};
               rem_d      = bus.req_ncl;
               err_d      = 1'b0;
               state_d    = (bus.req_ncl != 7'd0) ? ST_AR : ST_DONE;
            end
         end
         ST_AR: begin
            if (bus.m_axi_arready) begin
               bcnt_d  = arlen_q + 7'd1;
               state_d = ST_RD;
            end
         end
         ST_RD: begin
            if (r_hs) begin
               bcnt_d     = bcnt_q - 7'd1;
               rem_d      = rem_q - 7'd1;
               cur_addr_d = cur_addr_q + ADDR_W'(64);
               if (bus.m_axi_rresp != 2'b00) err_d = 1'b1;
               // rlast must coincide exactly with the counted final beat
               if (bus.m_axi_rlast != (bcnt_q == 7'd1)) err_d = 1'b1;
               if (bcnt_q == 7'd1) state_d = (rem_q != 7'd1) ? ST_AR : ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Burst length for the AR about to be issued: min(rem, BURST_MAX, lines left in the page)
      room_d = 7'd64 - {1'b0, cur_addr_d[11:6]};
      blen_d = rem_d;
      if (blen_d > BMAX)   blen_d = BMAX;
      if (blen_d > room_d) blen_d = room_d;
   end

   // State and bookkeeping registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         cur_addr_q <= '0;
         rem_q      <= '0;
         bcnt_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         rem_q      <= rem_d;
         bcnt_q     <= bcnt_d;
         err_q      <= err_d;
      end
   end

   // Registered AR payload, loaded when a new burst is about to be requested.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         araddr_q <= '0;
         arlen_q  <= '0;
      end else if (ar_load) begin
         araddr_q <= cur_addr_d;
         arlen_q  <= blen_d - 7'd1;
      end
   end

   assign bus.req_ready     = (state_q == ST_IDLE);
   assign bus.m_axi_arid    = ID_W'(RD_ID);
   assign bus.m_axi_araddr  = araddr_q;
   assign bus.m_axi_arlen   = {1'b0, arlen_q};
   assign bus.m_axi_arsize  = 3'd6;
   assign bus.m_axi_arburst = 2'b01;
   assign bus.m_axi_arvalid = (state_q == ST_AR);
   assign bus.m_axi_rready  = in_rd && bus.cl_ready;

   assign rdata             = bus.m_axi_rdata;
   assign bus.cl_data       = rdata;
   assign bus.cl_valid      = in_rd && bus.m_axi_rvalid;
   assign bus.cl_last       = in_rd && (rem_q == 7'd1);
   assign bus.done          = (state_q == ST_DONE);
   assign bus.err           = err_q;

endmodule

// File: tb/tb_hawk_pgrd_mngr.sv
// Bench for hawk_pgrd_mngr: a table of directed requests, then random requests, each run against
// a responding AXI slave and a consumer, with results compared to a burst-splitting model.
module tb_hawk_pgrd_mngr;

   localparam int BMAX = 16;

   logic clk = 1'b0;
   logic rst_ni;

   always #5 clk = ~clk;

   hawk_pgrd_mngr_if #(.ADDR_W(64), .DATA_W(512), .ID_W(4)) bus ();

   hawk_pgrd_mngr #(
      .ADDR_W(64), .DATA_W(512), .ID_W(4), .RD_ID(0), .BURST_MAX(BMAX)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_ni),
      .bus   (bus)
   );

   typedef struct {
      logic [63:0] addr;
      int          ncl;
      int          slverr_at;  // 1-based beat returning SLVERR, 0 = none
      int          flip_at;    // 1-based beat with rlast inverted, 0 = none
      int          mode;       // 0: always ready, 1: cl_ready toggles, 2: random
      int          exp_nar;
      bit          exp_err;
   } vec_t;

   int n_chk  = 0;
   int n_fail = 0;

   logic [63:0] m_addr[$];
   int          m_len[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_w(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [511:0] dat(input logic [63:0] a);
      logic [511:0] d;
      for (int i = 0; i < 8; i++) d[i*64 +: 64] = a + 64'(i) * 64'h0101_0000_0000_0000;
      return d;
   endfunction

   // Expected AR sequence: split into bursts of min(remaining, BMAX, lines left in the 4 KB page)
   task automatic build_model(input logic [63:0] addr, input int ncl);
      logic [63:0] a;
      int rem, b, room;
      m_addr.delete();
      m_len.delete();
      a   = addr & ~64'h3f;
      rem = ncl;
      while (rem > 0) begin
         room = 64 - int'(a[11:6]);
         b = rem;
         if (b > BMAX) b = BMAX;
         if (b > room) b = room;
         m_addr.push_back(a);
         m_len.push_back(b - 1);
         a   = a + 64'(b) * 64;
         rem = rem - b;
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_arvalid", bus.m_axi_arvalid, 0);
      chk("rst_araddr", bus.m_axi_araddr, 0);
      chk("rst_arlen", bus.m_axi_arlen, 0);
      chk("rst_rready", bus.m_axi_rready, 0);
      chk("rst_cl_valid", bus.cl_valid, 0);
      chk("rst_cl_last", bus.cl_last, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
   endtask

   // Runs one request with a responding slave and consumer; abort_after>0 stops mid-flight.
   task automatic run_req(input vec_t v, input int abort_after);
      logic [63:0]  ar_a[$];
      int           ar_l[$];
      logic [63:0]  sb_a[$];
      int           sb_l[$];
      logic [511:0] got_d[$];
      logic         got_last[$];
      int           beat = 0, g = 0, cyc = 0, last_cyc = -1, done_cyc = -1;
      bit           rv_pend = 0, p_stall = 0, done_err = 0;
      logic [63:0]  p_araddr;
      logic [7:0]   p_arlen;
      logic [63:0]  base;

      build_model(v.addr, v.ncl);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = v.addr;
      bus.req_ncl   = 7'(v.ncl);
      #1 chk("req_ready_idle", bus.req_ready, 1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_addr  = {$urandom, $urandom};
      bus.req_ncl   = 7'($urandom_range(0, 64));

      while (done_cyc < 0 && cyc < 3000) begin
         cyc++;
         if (cyc > 1) @(negedge clk);
         bus.m_axi_arready = (v.mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
         case (v.mode)
            0:       bus.cl_ready = 1'b1;
            1:       bus.cl_ready = 1'((cyc % 2) == 1);
            default: bus.cl_ready = 1'($urandom_range(0, 1));
         endcase
         if (!rv_pend) begin
            if (sb_a.size() > 0 && (v.mode == 0 || $urandom_range(0, 3) != 0)) begin
               bus.m_axi_rvalid = 1'b1;
               bus.m_axi_rdata  = dat(sb_a[0] + 64'(beat) * 64);
               bus.m_axi_rresp  = (g + 1 == v.slverr_at) ? 2'b10 : 2'b00;
               bus.m_axi_rlast  = (beat == sb_l[0]) ^ (g + 1 == v.flip_at);
               rv_pend = 1'b1;
            end else begin
               bus.m_axi_rvalid = 1'b0;
            end
         end
         #1;
         if (cyc == 1) begin
            chk("arvalid_after_accept", bus.m_axi_arvalid, (v.ncl != 0));
            chk("done_after_accept", bus.done, (v.ncl == 0));
         end
         if (p_stall) begin
            chk("araddr_stable", bus.m_axi_araddr, p_araddr);
            chk("arlen_stable", bus.m_axi_arlen, p_arlen);
         end
         p_stall  = bus.m_axi_arvalid && !bus.m_axi_arready;
         p_araddr = bus.m_axi_araddr;
         p_arlen  = bus.m_axi_arlen;
         if (sb_a.size() > 0) begin
            chk("rready_tracks_cl_ready", bus.m_axi_rready, bus.cl_ready);
            chk("cl_valid_tracks_rvalid", bus.cl_valid, bus.m_axi_rvalid);
         end
         if (bus.m_axi_rvalid && bus.m_axi_rready) begin
            got_d.push_back(bus.cl_data);
            got_last.push_back(bus.cl_last);
            g++;
            beat++;
            rv_pend  = 1'b0;
            last_cyc = cyc;
            if (beat > sb_l[0]) begin
               void'(sb_a.pop_front());
               void'(sb_l.pop_front());
               beat = 0;
            end
         end
         if (bus.m_axi_arvalid && bus.m_axi_arready) begin
            ar_a.push_back(bus.m_axi_araddr);
            ar_l.push_back(int'(bus.m_axi_arlen));
            sb_a.push_back(bus.m_axi_araddr);
            sb_l.push_back(int'(bus.m_axi_arlen));
         end
         if (bus.done) begin
            done_cyc = cyc;
            done_err = bus.err;
            chk("req_ready_low_in_done", bus.req_ready, 0);
         end
         if (abort_after != 0 && cyc == abort_after) return;
      end
      bus.m_axi_rvalid  = 1'b0;
      bus.m_axi_arready = 1'b0;

      chk("done_seen", (done_cyc >= 0), 1);
      chk("n_ar", ar_a.size(), v.exp_nar);
      chk("n_ar_model", ar_a.size(), m_addr.size());
      for (int i = 0; i < m_addr.size() && i < ar_a.size(); i++) begin
         chk("araddr", ar_a[i], m_addr[i]);
         chk("arlen", ar_l[i], m_len[i]);
      end
      chk("n_beats", got_d.size(), v.ncl);
      base = v.addr & ~64'h3f;
      for (int i = 0; i < v.ncl && i < got_d.size(); i++) begin
         chk_w("cl_data", got_d[i], dat(base + 64'(i) * 64));
         chk("cl_last", got_last[i], (i == v.ncl - 1));
      end
      chk("err_at_done", done_err, v.exp_err);
      if (v.ncl != 0 && done_cyc >= 0) chk("done_latency", done_cyc - last_cyc, 1);
      @(negedge clk);
      #1;
      chk("done_one_cycle", bus.done, 0);
      chk("req_ready_after_done", bus.req_ready, 1);
      chk("err_held", bus.err, v.exp_err);
   endtask

   initial begin
      vec_t tbl[8];
      vec_t v;

      tbl[0] = '{64'h1000_0040, 1,  0, 0, 0, 1, 1'b0};  // single line
      tbl[1] = '{64'h2000_0000, 64, 0, 0, 0, 4, 1'b0};  // full page
      tbl[2] = '{64'h3000_0fc0, 4,  0, 0, 2, 2, 1'b0};  // 4 KB split
      tbl[3] = '{64'h4000_0000, 8,  3, 0, 1, 1, 1'b1};  // SLVERR + backpressure
      tbl[4] = '{64'h5000_0000, 4,  0, 2, 0, 1, 1'b1};  // early rlast
      tbl[5] = '{64'h5000_0100, 4,  0, 0, 2, 1, 1'b0};  // clean after error
      tbl[6] = '{64'h6000_0000, 0,  0, 0, 0, 0, 1'b0};  // ncl = 0
      tbl[7] = '{64'h7000_0fff, 3,  0, 0, 1, 2, 1'b0};  // low bits ignored, split

      rst_ni            = 1'b0;
      bus.req_valid     = 1'b0;
      bus.req_addr      = '0;
      bus.req_ncl       = '0;
      bus.m_axi_arready = 1'b1;
      bus.m_axi_rdata   = '0;
      bus.m_axi_rresp   = 2'b00;
      bus.m_axi_rlast   = 1'b0;
      bus.m_axi_rvalid  = 1'b1;
      bus.cl_ready      = 1'b1;
      repeat (3) @(negedge clk);
      #1 check_reset_outputs();
      @(negedge clk);
      bus.m_axi_rvalid  = 1'b0;
      rst_ni            = 1'b1;

      for (int i = 0; i < 8; i++) run_req(tbl[i], 0);

      for (int i = 0; i < 20; i++) begin
         v.addr      = {$urandom, $urandom};
         v.ncl       = $urandom_range(0, 64);
         v.slverr_at = (v.ncl > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, v.ncl) : 0;
         v.flip_at   = (v.ncl > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, v.ncl) : 0;
         v.mode      = $urandom_range(0, 2);
         build_model(v.addr, v.ncl);
         v.exp_nar   = m_addr.size();
         v.exp_err   = (v.slverr_at != 0) || (v.flip_at != 0);
         run_req(v, 0);
      end

      // Reset in the middle of a burst with err already set, then a normal request
      v = '{64'h8000_0000, 64, 1, 0, 0, 4, 1'b1};
      run_req(v, 20);
      chk("err_set_before_reset", bus.err, 1);
      rst_ni = 1'b0;
      #1 check_reset_outputs();
      @(negedge clk);
      bus.m_axi_rvalid = 1'b0;
      rst_ni           = 1'b1;
      run_req(tbl[2], 0);
      run_req(tbl[6], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hawk_pgrd_mngr.md
# hawk_pgrd_mngr

Page read manager for the HAWK compression datapath: the read-side counterpart of the page write manager. It accepts a request to read N consecutive 64 B cachelines and issues AXI4 INCR read bursts toward the HAWK/CPU crossbar. It streams the returned cachelines to the consumer with valid/ready backpressure and reports completion with a sticky error status. The ATT/free-list initialisation path and the decompressor use it to fetch pages from DDR.

## Interface
- ADDR_W, 64: AXI address width.
- DATA_W, 512: data width; one beat is one cacheline.
- ID_W, 4: AXI ID width.
- RD_ID, 0: constant arid value.
- BURST_MAX, 16: maximum beats per burst; power of two, 1..64.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; **one clock; reset is asynchronous and active-low.**
- req_valid  in  1  read request valid.
- req_ready  out  1  request accepted; high only in IDLE.
- req_addr  in  ADDR_W  start byte address; bits [5:0] ignored (treated as 0).
- req_ncl  in  7  cachelines to read, 0..64.
- m_axi_arid  out  ID_W  = RD_ID.
- m_axi_araddr  out  ADDR_W  burst start address.
- m_axi_arlen  out  8  beats-1.
- m_axi_arsize  out  3  constant 3'd6.
- m_axi_arburst  out  2  constant 2'b01 (INCR).
- m_axi_arvalid / m_axi_arready  out / in  1  AR handshake.
- m_axi_rdata  in  DATA_W  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rlast  in  1  last beat of burst.
- m_axi_rvalid / m_axi_rready  in / out  1  R handshake.
- cl_data  out  DATA_W  cacheline to consumer (= rdata).
- cl_valid / cl_ready  out / in  1  consumer handshake.
- cl_last  out  1  final cacheline of the whole request.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error for the last request; valid while done=1 and held until the next accept.

## Operation
- FSM states: IDLE, AR, RD, DONE.
- **IDLE**
  - req_ready=1.
  - On req_valid: latch cur_addr = {req_addr[ADDR_W-1:6], 6'b0} and rem = req_ncl, and clear err.
  - Go to AR if req_ncl≠0; otherwise go to DONE.
- **AR**
  - Burst length blen = min(rem, BURST_MAX, 64 − cur_addr[11:6]). Bursts never cross a 4 KB boundary.
  - Drive arvalid=1, araddr=cur_addr, arlen=blen−1.
  - araddr/arlen are registered and stable while arvalid=1.
  - On arready: beat counter bcnt=blen, then go to RD.
- **RD**
  - cl_valid = rvalid; rready = cl_ready. Pure pass-through, no buffering.
  - On each R handshake: decrement bcnt and rem, and add 64 to cur_addr.
  - cl_last=1 when rem==1.
  - rresp≠2'b00 sets err; the beat is still forwarded.
  - rlast on a beat where bcnt≠1 sets err. bcnt==1 without rlast also sets err.
  - Bursts are always terminated by the beat count, not by rlast.
  - When bcnt reaches 0: go to AR if rem≠0, else DONE.
- **DONE**
  - done=1 for exactly one cycle, then IDLE.
- Only one burst is outstanding at a time. R beats with a mismatched rid are not checked.
- Outside RD: rready=0 and cl_valid=0.

## Timing
- Reset values: req_ready=1 (IDLE), arvalid=0, araddr=0, arlen=0, rready=0, cl_valid=0, cl_last=0, done=0, err=0.
- Request accepted at edge N → arvalid=1 in cycle N+1.
- AR handshake at edge M → rready may assert in cycle M+1.
- After the final beat of a non-final burst, arvalid re-asserts the next cycle.
- After the final beat of the request, done=1 the next cycle and req_ready=1 the cycle after.
- req_ncl=0: done pulses in cycle N+1, err=0, no AXI traffic.
- Throughput: one cacheline per cycle within a burst. Each inter-burst gap is ≥1 idle cycle plus AR latency.
- cl_data/cl_valid/cl_last are combinational from rdata/rvalid and state. Consumers must not assume registered outputs.
- Asynchronous reset mid-operation: return to IDLE immediately and drop arvalid/rready. Any in-flight AXI beats are abandoned; the system resets the crossbar together with this block.

## Test plan
- **Single line:** req_addr=0x1000_0040, ncl=1 → one AR with araddr=0x1000_0040, arlen=0; one cl beat with cl_last=1; done one cycle later with err=0.
- **Full page:** addr=0x2000_0000, ncl=64 → four ARs (0x…000, 0x…400, 0x…800, 0x…C00), each arlen=15; 64 beats in order; cl_last only on beat 64.
- **4 KB split:** addr=0x3000_0FC0, ncl=4 → AR 0x3000_0FC0 arlen=0, then AR 0x3000_1000 arlen=2; 4 beats total.
- **Error and backpressure:**
  - rresp=SLVERR on beat 3 of 8, with cl_ready toggling 1/0 each cycle.
  - Required: all 8 beats delivered with no loss or duplication; rready tracks cl_ready; err=1 at done.
- **rlast misuse:**
  - rlast on beat 2 of a 4-beat burst → err=1, and all 4 beats are still consumed.
  - A subsequent request with clean responses → err=0.
- **Reset mid-burst and ncl=0:**
  - rst_ni low during RD → outputs at reset values in the same cycle; next request works normally.
  - ncl=0 → done only, no arvalid.
